// File: rtl/qdiv_share_pkg.sv
// Shared types and default widths for the divider-sharing controller.
package qdiv_share_pkg;

  localparam int unsigned DefaultQ      = 15;
  localparam int unsigned DefaultN      = 32;
  localparam int unsigned DefaultNumReq = 4;

  typedef enum logic [2:0] {
    StFlush,
    StIdle,
    StStart,
    StArmed,
    StBusy,
    StResp
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: circular search starting at ptr_i+1, one-hot grant plus binary index.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    // The current owner (offset NUM_REQ) is searched last.
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand     = (32'(ptr_i) + off) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req_i[cand_idx]) begin
        found           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/qdiv_share_ctrl.sv
// Time-shares one sequential sign-magnitude divider among NUM_REQ round-robin requesters.
// Optional macro QDIV_SHARE_DIVZERO_EN answers zero-divisor requests without using the divider.
module qdiv_share_ctrl
  import qdiv_share_pkg::*;
#(
  parameter int unsigned Q       = DefaultQ,
  parameter int unsigned N       = DefaultN,
  parameter int unsigned NUM_REQ = DefaultNumReq,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  output logic [NUM_REQ-1:0]   o_req_ready,
  input  logic [NUM_REQ*N-1:0] i_req_dividend,
  input  logic [NUM_REQ*N-1:0] i_req_divisor,
  output logic [NUM_REQ-1:0]   o_rsp_valid,
  input  logic [NUM_REQ-1:0]   i_rsp_ready,
  output logic [N-1:0]         o_rsp_quotient,
  output logic                 o_rsp_overflow,
  output logic [IDX_W-1:0]     o_rsp_idx,
  output logic                 o_div_start,
  output logic [N-1:0]         o_div_dividend,
  output logic [N-1:0]         o_div_divisor,
  input  logic [N-1:0]         i_div_quotient,
  input  logic                 i_div_complete,
  input  logic                 i_div_overflow
);

  if (NUM_REQ < 2 || Q >= N) begin : gen_param_err
    $error("qdiv_share_ctrl: need NUM_REQ >= 2 and Q < N");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     dvd_q, dvd_d;
  logic [N-1:0]     dvs_q, dvs_d;
  logic [N-1:0]     quot_q, quot_d;
  logic             ovf_q, ovf_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic [N-1:0]       win_dvd;
  logic [N-1:0]       win_dvs;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i (i_req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  assign win_dvd = i_req_dividend[gnt_idx*N +: N];
  assign win_dvs = i_req_divisor[gnt_idx*N +: N];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    quot_d      = quot_q;
    ovf_d       = ovf_q;
    o_req_ready = '0;
    o_div_start = 1'b0;
    o_rsp_valid = '0;

    unique case (state_q)
      // The divider has no reset; wait out any operation left over from before reset.
      StFlush: begin
        if (i_div_complete) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        o_req_ready = gnt;
        if (gnt_any) begin
          ptr_d   = gnt_idx;
          idx_d   = gnt_idx;
          dvd_d   = win_dvd;
          dvs_d   = win_dvs;
          state_d = StStart;
`ifdef QDIV_SHARE_DIVZERO_EN
          if (win_dvs[N-2:0] == '0) begin
            quot_d  = {win_dvd[N-1] ^ win_dvs[N-1], {(N-1){1'b1}}};
            ovf_d   = 1'b1;
            state_d = StResp;
          end
`endif
        end
      end
      StStart: begin
        o_div_start = 1'b1;
        state_d     = StArmed;
      end
      // Complete is still stale-high the cycle after start.
      StArmed: begin
        state_d = StBusy;
      end
      StBusy: begin
        if (i_div_complete) begin
          quot_d  = i_div_quotient;
          ovf_d   = i_div_overflow;
          state_d = StResp;
        end
      end
      StResp: begin
        o_rsp_valid[idx_q] = 1'b1;
        if (i_rsp_ready[idx_q]) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StFlush;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StFlush;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      idx_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_div_dividend = dvd_q;
  assign o_div_divisor  = dvs_q;
  assign o_rsp_quotient = quot_q;
  assign o_rsp_overflow = ovf_q;
  assign o_rsp_idx      = idx_q;

endmodule
